cy_width_packer: RTL and testbench
==================================

// Module: cy_width_packer
// PURPOSE
//  Packs RATIO consecutive DW-bit beats into one DW*RATIO-bit word.
//  Sits directly downstream of cy_skidbuffer: consumes its o_valid/o_data and drives its i_ready.
//  Feeds wide-word consumers. The registered output plus a one-word pending slot keep
//  sustained 1 beat/clk while o_ready stays a registered signal.
// PARAMETERS
//  DW     8   narrow beat width in bits (>=1)
//  RATIO  4   beats per output word (>=2). Localparam CW = $clog2(RATIO+1).
// PORTS
//  i_clk    in   1         clock, all state on posedge
//  i_reset  in   1         asynchronous, active-high reset
//  i_valid  in   1         upstream beat valid
//  o_ready  out  1         upstream ready, registered (= !pend)
//  i_data   in   DW        upstream beat
//  o_valid  out  1         output word valid, registered
//  i_ready  in   1         downstream ready
//  o_data   out  DW*RATIO  packed word; beat k of the word sits in o_data[k*DW +: DW]
//  i_last   in   1         [CY_PACKER_LAST_EN only] closes the word on this beat
//  o_last   out  1         [CY_PACKER_LAST_EN only] word was closed by i_last
//  o_count  out  CW        [CY_PACKER_LAST_EN only] number of valid beats in o_data, 1..RATIO
// BEHAVIOUR
//  - Handshakes: accept = i_valid && o_ready; drain = o_valid && i_ready.
//  - State: acc (DW*RATIO), cnt (0..RATIO-1), pend flag, output regs.
//  - Accepted beat is written to acc lane cnt.
//  - Non-closing beat: cnt <= cnt+1.
//  - Closing beat (cnt==RATIO-1, or i_last with macro) moves the word, including the current
//    beat, out of the accumulator:
//      * Output slot free (!o_valid || i_ready): word goes straight to o_data; o_valid <= 1.
//      * Otherwise: word stays in acc and pend <= 1.
//    In both cases cnt <= 0.
//  - Pending drain: while pend, if (!o_valid || i_ready), acc moves to o_data, o_valid <= 1,
//    pend <= 0, acc <= 0.
//    o_ready is low while pend is set, so no beat can overwrite acc.
//  - If the output slot drains with nothing to replace it, o_valid <= 0.
//  - Hold: while o_valid && !i_ready, o_data/o_last/o_count stay stable.
//  - Latency: closing beat accepted at edge n gives o_valid=1 after edge n when the slot is
//    free. Otherwise the word moves out one edge after the slot frees.
//  - Throughput: 1 beat/clk with i_ready=1; o_ready never drops in that case.
//  - After a word leaves acc, acc is cleared to 0. Unused lanes of a partial word are 0.
//  - o_ready does not depend combinationally on i_valid, i_data or i_ready.
//  - Reset (asynchronous, any time, including mid-word or mid-pending):
//      * Cleared immediately without a clock edge: cnt, pend, acc, o_valid, o_data, o_last, o_count.
//      * o_ready reads 1 after reset.
//      * Partial words are discarded.
//      * No beat is accepted while i_reset=1.
// CONFIGURATION
//  CY_PACKER_LAST_EN defined:
//   - Ports i_last/o_last/o_count exist.
//   - An accepted beat with i_last=1 closes the word early, at any cnt.
//   - o_count = cnt+1 at close; o_last=1.
//   - A full word without i_last gives o_count=RATIO, o_last=0.
//   - The pending rule applies unchanged.
//  CY_PACKER_LAST_EN undefined:
//   - Ports are absent. Every word is exactly RATIO beats.
// TESTING
//  1. DW=8, RATIO=4, i_ready=1, beats 11,22,33,44 on back-to-back clocks
//     -> o_valid=1 one clk after 4th beat, o_data=32'h44332211, for 1 clk.
//  2. i_ready=0, 8 beats 11..88 -> o_data=32'h44332211 held; pend set at 8th beat, o_ready=0,
//     9th beat not accepted; i_ready=1 -> 32'h44332211 then 32'h88776655 on consecutive clks,
//     o_ready=1 the clk after pend clears.
//  3. 16 beats streamed, i_ready=1 -> 4 words, o_ready constantly 1, no gaps.
//  4. 2 beats accepted, then i_reset pulse between edges -> o_valid/o_data=0 immediately;
//     next beats A1,A2,A3,A4 -> 32'hA4A3A2A1.
//  5. [LAST_EN] beats AA,BB,CC with i_last on CC -> o_data=32'h00CCBBAA, o_count=3, o_last=1;
//     next beat lands in lane 0.
//  6. [LAST_EN] output held (i_ready=0), single beat 5A with i_last -> pend=1, o_ready=0;
//     i_ready=1 -> o_data=32'h0000005A, o_count=1, o_last=1.

Source files
------------

// File: rtl/cy_width_packer.sv
// Packs RATIO consecutive DW-bit beats into one DW*RATIO-bit word, with a one-word pending slot.
// Optional early word close (i_last/o_last/o_count) is enabled by defining CY_PACKER_LAST_EN.
module cy_width_packer #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  localparam int CW   = $clog2(RATIO + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DW-1:0]       i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DW*RATIO-1:0] o_data
`ifdef CY_PACKER_LAST_EN
  ,
  input  logic                i_last,
  output logic                o_last,
  output logic [CW-1:0]       o_count
`endif
);

  logic [DW*RATIO-1:0] acc_reg;
  logic [CW-1:0]       cnt_reg;
  logic                pend_reg;
  logic                valid_reg;
  logic [DW*RATIO-1:0] data_reg;

  logic [DW*RATIO-1:0] acc_next_word;
  logic                accept;
  logic                slot_free;
  logic                last_lane;
  logic                closing;

  // Accumulator with the incoming beat dropped into lane cnt_reg
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign acc_next_word[gi*DW +: DW] =
        (cnt_reg == CW'(gi)) ? i_data : acc_reg[gi*DW +: DW];
    end
  endgenerate

  assign o_ready   = !pend_reg;
  assign accept    = i_valid && !pend_reg;
  assign slot_free = !valid_reg || i_ready;
  assign last_lane = (cnt_reg == CW'(RATIO - 1));

`ifdef CY_PACKER_LAST_EN
  logic          last_reg;
  logic [CW-1:0] count_reg;
  logic          pend_last_reg;
  logic [CW-1:0] pend_count_reg;
  logic [CW-1:0] close_count;

  assign closing     = last_lane || i_last;
  assign close_count = cnt_reg + CW'(1);
  assign o_last      = last_reg;
  assign o_count     = count_reg;
`else
  assign closing = last_lane;
`endif

  assign o_valid = valid_reg;
  assign o_data  = data_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      pend_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      data_reg       <= '0;
`ifdef CY_PACKER_LAST_EN
      last_reg       <= 1'b0;
      count_reg      <= '0;
      pend_last_reg  <= 1'b0;
      pend_count_reg <= '0;
`endif
    end else begin
      // Drained slot empties unless something below refills it this cycle
      if (valid_reg && i_ready) begin
        valid_reg <= 1'b0;
      end

      if (pend_reg) begin
        if (slot_free) begin
          valid_reg <= 1'b1;
          data_reg  <= acc_reg;
          acc_reg   <= '0;
          pend_reg  <= 1'b0;
`ifdef CY_PACKER_LAST_EN
          last_reg  <= pend_last_reg;
          count_reg <= pend_count_reg;
`endif
        end
      end else if (accept) begin
        if (closing) begin
          cnt_reg <= '0;
          if (slot_free) begin
            valid_reg <= 1'b1;
            data_reg  <= acc_next_word;
            acc_reg   <= '0;
`ifdef CY_PACKER_LAST_EN
            last_reg  <= i_last;
            count_reg <= close_count;
`endif
          end else begin
            // Output occupied: park the finished word in acc and stall upstream
            acc_reg  <= acc_next_word;
            pend_reg <= 1'b1;
`ifdef CY_PACKER_LAST_EN
            pend_last_reg  <= i_last;
            pend_count_reg <= close_count;
`endif
          end
        end else begin
          acc_reg <= acc_next_word;
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cy_width_packer.sv
// Self-checking bench for cy_width_packer: directed scenarios plus a randomized run against a
// beat-queue reference model. Define CY_PACKER_LAST_EN to also exercise early word close.
module tb_cy_width_packer;

  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int WW    = DW * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [WW-1:0] o_data;
`ifdef CY_PACKER_LAST_EN
  logic          i_last;
  logic          o_last;
  logic [CW-1:0] o_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] beat_q[$];
  logic [WW-1:0] exp_data_q[$];
  int            exp_count_q[$];
  bit            exp_last_q[$];

  always #5 i_clk = ~i_clk;

  cy_width_packer #(.DW(DW), .RATIO(RATIO)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
`ifdef CY_PACKER_LAST_EN
    ,
    .i_last  (i_last),
    .o_last  (o_last),
    .o_count (o_count)
`endif
  );

  // Reference: collect accepted beats, a word is emitted after RATIO beats or on a last beat
  task automatic model_beat(input logic [DW-1:0] d, input bit last);
    logic [WW-1:0] w;
    beat_q.push_back(d);
    if (beat_q.size() == RATIO || last) begin
      w = '0;
      for (int k = 0; k < beat_q.size(); k++) w[k*DW +: DW] = beat_q[k];
      exp_data_q.push_back(w);
      exp_count_q.push_back(beat_q.size());
      exp_last_q.push_back(last);
      beat_q.delete();
    end
  endtask

  task automatic model_clear();
    beat_q.delete();
    exp_data_q.delete();
    exp_count_q.delete();
    exp_last_q.delete();
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
`ifdef CY_PACKER_LAST_EN
    i_last  = 1'b0;
`endif
    #12;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", o_ready); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL rst_data got=%h want=0", o_data); end
`ifdef CY_PACKER_LAST_EN
    checks++; if (o_count !== '0 || o_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%0d/%b want=0/0", o_count, o_last); end
`endif
    step();
    i_reset = 1'b0;
    step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b want=0", o_valid); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid beat=%0d got=%b want=0", k, o_valid); end
      i_valid = 1'b1;
      i_data  = DW'(8'h11 * (k + 1));
      step();
    end
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", o_valid); end
    checks++; if (o_data !== 32'h44332211) begin failures++; $display("FAIL basic_data got=%h want=44332211", o_data); end
    step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_one_clk got=%b want=0", o_valid); end
    $display("test_basic word=44332211");
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready beat=%0d got=%b want=1", k, o_ready); end
      i_valid = 1'b1;
      i_data  = DW'(8'h11 * (k + 1));
      step();
    end
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b want=1", o_valid); end
    checks++; if (o_data !== 32'h44332211) begin failures++; $display("FAIL bp_first got=%h want=44332211", o_data); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_pend_ready got=%b want=0", o_ready); end
    i_data = 8'h99;
    step();
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_still_pend got=%b want=0", o_ready); end
    checks++; if (o_data !== 32'h44332211) begin failures++; $display("FAIL bp_hold got=%h want=44332211", o_data); end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%b want=1", o_valid); end
    checks++; if (o_data !== 32'h88776655) begin failures++; $display("FAIL bp_second got=%h want=88776655", o_data); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b want=1", o_ready); end
    step();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b want=0", o_valid); end
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_data  = DW'(k + 1);
      step();
    end
    i_valid = 1'b0;
    checks++; if (o_data !== 32'h04030201) begin failures++; $display("FAIL bp_after got=%h want=04030201", o_data); end
    step();
    $display("test_backpressure words=44332211,88776655,04030201");
  endtask

  task automatic test_stream();
    int words;
    logic [DW-1:0] d;
    model_clear();
    words   = 0;
    i_ready = 1'b1;
    for (int k = 0; k < 16 + 2; k++) begin
      if (k < 16) begin
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b want=1", k, o_ready); end
      end
      if (o_valid) begin
        words++;
        checks++;
        if (exp_data_q.size() == 0) begin
          failures++; $display("FAIL stream_extra got=%h want=none", o_data);
        end else begin
          if (o_data !== exp_data_q[0]) begin failures++; $display("FAIL stream_data got=%h want=%h", o_data, exp_data_q[0]); end
          void'(exp_data_q.pop_front());
          void'(exp_count_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      if (k < 16) begin
        d       = DW'($urandom);
        i_valid = 1'b1;
        i_data  = d;
        model_beat(d, 1'b0);
      end else begin
        i_valid = 1'b0;
      end
      step();
    end
    checks++; if (words != 4) begin failures++; $display("FAIL stream_words got=%0d want=4", words); end
    $display("test_stream words=%0d", words);
  endtask

  task automatic test_reset_midword();
    i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_data  = DW'(8'hB1 + k);
      step();
    end
    i_valid = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b want=0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL arst_data got=%h want=0", o_data); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b want=1", o_ready); end
    #1 i_reset = 1'b0;
    step();
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_data  = DW'(8'hA1 + k);
      step();
    end
    i_valid = 1'b0;
    checks++; if (o_data !== 32'hA4A3A2A1) begin failures++; $display("FAIL arst_next got=%h want=a4a3a2a1", o_data); end
    step();
    $display("test_reset_midword word=a4a3a2a1");
  endtask

`ifdef CY_PACKER_LAST_EN
  task automatic test_last_early();
    logic [DW-1:0] b[3];
    b = '{8'hAA, 8'hBB, 8'hCC};
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = b[k];
      i_last  = (k == 2);
      step();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    checks++; if (o_data !== 32'h00CCBBAA) begin failures++; $display("FAIL last_data got=%h want=00ccbbaa", o_data); end
    checks++; if (o_count !== CW'(3)) begin failures++; $display("FAIL last_count got=%0d want=3", o_count); end
    checks++; if (o_last !== 1'b1) begin failures++; $display("FAIL last_flag got=%b want=1", o_last); end
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_data  = DW'(8'h11 * (k + 1));
      step();
    end
    i_valid = 1'b0;
    checks++; if (o_data !== 32'h44332211) begin failures++; $display("FAIL last_lane0 got=%h want=44332211", o_data); end
    checks++; if (o_count !== CW'(4) || o_last !== 1'b0) begin failures++; $display("FAIL last_full got=%0d/%b want=4/0", o_count, o_last); end
    step();
    $display("test_last_early word=00ccbbaa");
  endtask

  task automatic test_last_pend();
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_data  = DW'(k + 1);
      step();
    end
    i_data = 8'h5A;
    i_last = 1'b1;
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL lpend_ready got=%b want=0", o_ready); end
    checks++; if (o_data !== 32'h04030201) begin failures++; $display("FAIL lpend_hold got=%h want=04030201", o_data); end
    i_ready = 1'b1;
    step();
    checks++; if (o_data !== 32'h0000005A) begin failures++; $display("FAIL lpend_data got=%h want=0000005a", o_data); end
    checks++; if (o_count !== CW'(1) || o_last !== 1'b1) begin failures++; $display("FAIL lpend_last got=%0d/%b want=1/1", o_count, o_last); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL lpend_ready_back got=%b want=1", o_ready); end
    step();
    $display("test_last_pend word=0000005a");
  endtask
`endif

  task automatic test_random();
    bit            hold_prev;
    logic [WW-1:0] prev_data;
    bit            last_bit;
    int            nwords;
    model_clear();
    hold_prev = 1'b0;
    prev_data = '0;
    nwords    = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (hold_prev) begin
        checks++; if (o_valid !== 1'b1 || o_data !== prev_data) begin failures++; $display("FAIL rnd_hold cyc=%0d got=%b/%h want=1/%h", cyc, o_valid, o_data, prev_data); end
      end
      checks++; if (!o_ready && !o_valid) begin failures++; $display("FAIL rnd_stall cyc=%0d ready=%b valid=%b", cyc, o_ready, o_valid); end
      last_bit = 1'b0;
      if (cyc < 400) begin
        i_valid = ($urandom_range(0, 9) < 7);
        i_ready = ($urandom_range(0, 9) < 6);
        i_data  = DW'($urandom);
`ifdef CY_PACKER_LAST_EN
        last_bit = ($urandom_range(0, 4) == 0);
        i_last   = last_bit;
`endif
      end else begin
        i_valid = 1'b0;
        i_ready = 1'b1;
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          failures++; $display("FAIL rnd_extra cyc=%0d got=%h want=none", cyc, o_data);
        end else begin
          if (o_data !== exp_data_q[0]) begin
            failures++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, o_data, exp_data_q[0]);
          end else begin
            $display("rnd word %0d data=%h", nwords, o_data);
          end
`ifdef CY_PACKER_LAST_EN
          checks++;
          if (o_count !== CW'(exp_count_q[0]) || o_last !== exp_last_q[0]) begin
            failures++; $display("FAIL rnd_meta cyc=%0d got=%0d/%b want=%0d/%b", cyc, o_count, o_last, exp_count_q[0], exp_last_q[0]);
          end
`endif
          void'(exp_data_q.pop_front());
          void'(exp_count_q.pop_front());
          void'(exp_last_q.pop_front());
        end
        nwords++;
      end
      if (i_valid && o_ready) model_beat(i_data, last_bit);
      hold_prev = o_valid && !i_ready;
      prev_data = o_data;
      step();
    end
`ifdef CY_PACKER_LAST_EN
    i_last = 1'b0;
`endif
    checks++; if (exp_data_q.size() != 0) begin failures++; $display("FAIL rnd_leftover got=%0d want=0", exp_data_q.size()); end
    checks++; if (nwords < 20) begin failures++; $display("FAIL rnd_words got=%0d want>=20", nwords); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_reset_midword();
`ifdef CY_PACKER_LAST_EN
    test_last_early();
    test_last_pend();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
